// File: rtl/red_pitaya_acq_ch_pkg.sv
// ----------------------------------------------------------------------------
// acq_pkg: shared types and constants for the single-channel acquisition block.
//   acq_state_t : capture FSM state encoding
//   TRG_*       : trigger source selector codes (6 and 7 behave as TRG_NONE)
//   DEC_W       : decimation factor width
//   dec_last()  : terminal count of the decimation counter
// ----------------------------------------------------------------------------
package acq_pkg;

   localparam int unsigned DEC_W = 17;
   localparam int unsigned SRC_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      TRIG  = 2'd2,
      DONE  = 2'd3
   } acq_state_t;

   localparam logic [SRC_W-1:0] TRG_NONE  = 3'd0;
   localparam logic [SRC_W-1:0] TRG_SW    = 3'd1;
   localparam logic [SRC_W-1:0] TRG_EXT_R = 3'd2;
   localparam logic [SRC_W-1:0] TRG_EXT_F = 3'd3;
   localparam logic [SRC_W-1:0] TRG_LVL   = 3'd4;
   localparam logic [SRC_W-1:0] TRG_NOW   = 3'd5;

   // Last count value of the decimator: factors 0 and 1 both mean "every clock".
   function automatic logic [DEC_W-1:0] dec_last(input logic [DEC_W-1:0] dec);
      return (dec <= DEC_W'(1)) ? '0 : dec - DEC_W'(1);
   endfunction

endpackage : acq_pkg

// File: rtl/red_pitaya_acq_ch_trig_det.sv
// ----------------------------------------------------------------------------
// acq_trig_det: trigger detection for the acquisition channel.
//   clk_i, rst_i   : clock, async active-high reset
//   en_i           : FSM qualifier, trig_o can only fire while high
//   arm_i          : arm pulse, clears the previous-sample register
//   smp_v_i, smp_i : decimated sample strobe and the sample being stored
//   src_i          : trigger source select (TRG_* codes)
//   trig_sw_i      : software trigger, used as-is
//   trig_ext_i     : asynchronous external trigger pin
//   thr_i          : signed level threshold
//   trig_o         : single-cycle trigger, combinational from registered state
// ----------------------------------------------------------------------------
module acq_trig_det
   import acq_pkg::*;
#(
   parameter int unsigned DW = 14
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 arm_i,
   input  logic                 smp_v_i,
   input  logic signed [DW-1:0] smp_i,
   input  logic [SRC_W-1:0]     src_i,
   input  logic                 trig_sw_i,
   input  logic                 trig_ext_i,
   input  logic signed [DW-1:0] thr_i,
   output logic                 trig_o
);

   logic                 r_ext_s1;
   logic                 r_ext_s2;
   logic                 r_ext_d;
   logic signed [DW-1:0] r_prev;

   logic w_ext_rise;
   logic w_ext_fall;
   logic w_lvl;
   logic w_hit;

   // Two-flop synchronizer, one edge-detect flop, previous-sample tracker.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ext_s1 <= 1'b0;
         r_ext_s2 <= 1'b0;
         r_ext_d  <= 1'b0;
         r_prev   <= '0;
      end else begin
         r_ext_s1 <= trig_ext_i;
         r_ext_s2 <= r_ext_s1;
         r_ext_d  <= r_ext_s2;
         if (arm_i) begin
            r_prev <= '0;
         end else if (smp_v_i) begin
            r_prev <= smp_i;
         end
      end
   end

   assign w_ext_rise = r_ext_s2 & ~r_ext_d;
   assign w_ext_fall = ~r_ext_s2 & r_ext_d;

   // Rising crossing: previous below threshold, current at or above it.
   assign w_lvl = smp_v_i && (r_prev < thr_i) && (thr_i <= smp_i);

   // Source select.
   always_comb begin
      w_hit = 1'b0;
      case (src_i)
         TRG_SW:    w_hit = trig_sw_i;
         TRG_EXT_R: w_hit = w_ext_rise;
         TRG_EXT_F: w_hit = w_ext_fall;
         TRG_LVL:   w_hit = w_lvl;
         TRG_NOW:   w_hit = 1'b1;
         default:   w_hit = 1'b0;
      endcase
   end

   assign trig_o = en_i & w_hit;

endmodule : acq_trig_det

// File: rtl/red_pitaya_acq_ch.sv
// ----------------------------------------------------------------------------
// red_pitaya_acq_ch: single-channel ADC acquisition into a circular buffer.
//   adc_clk_i, adc_rst_i : clock, async active-high reset
//   adc_dat_i            : signed ADC sample, one per clock
//   trig_sw_i/ext_i      : software pulse / asynchronous external pin
//   trig_src_i           : trigger source select
//   set_dec_i            : decimation factor (0 and 1 = none)
//   set_dly_i            : post-trigger sample count
//   set_thr_i            : signed level-trigger threshold
//   set_arm_i, set_rst_i : arm pulse, synchronous abort pulse
//   buf_addr_i/rdata_o   : readback port, one-cycle latency, read-before-write
//   buf_wpnt_o/tpnt_o    : write pointer / pointer latched at trigger
//   trig_done_o          : one-cycle pulse on entry to DONE
//   acq_busy_o           : high while ARMED or TRIG
// ----------------------------------------------------------------------------
module red_pitaya_acq_ch
   import acq_pkg::*;
#(
   parameter int unsigned RSZ = 14,
   parameter int unsigned DW  = 14
) (
   input  logic                 adc_clk_i,
   input  logic                 adc_rst_i,
   input  logic signed [DW-1:0] adc_dat_i,
   input  logic                 trig_sw_i,
   input  logic                 trig_ext_i,
   input  logic [SRC_W-1:0]     trig_src_i,
   input  logic [DEC_W-1:0]     set_dec_i,
   input  logic [31:0]          set_dly_i,
   input  logic signed [DW-1:0] set_thr_i,
   input  logic                 set_arm_i,
   input  logic                 set_rst_i,
   input  logic [RSZ-1:0]       buf_addr_i,
   output logic [DW-1:0]        buf_rdata_o,
   output logic [RSZ-1:0]       buf_wpnt_o,
   output logic [RSZ-1:0]       buf_tpnt_o,
   output logic                 trig_done_o,
   output logic                 acq_busy_o
);

   localparam int unsigned DEPTH = 2 ** RSZ;

   logic [DW-1:0]    r_ram [DEPTH];

   acq_state_t       r_state;
   logic [RSZ-1:0]   r_wpnt;
   logic [RSZ-1:0]   r_tpnt;
   logic [31:0]      r_dly_cnt;
   logic [DEC_W-1:0] r_dec_cnt;
   logic [DW-1:0]    r_adc;
   logic [DW-1:0]    r_rdata;
   logic             r_done;
   logic             r_busy;

   logic [DEC_W-1:0] w_dec_last;
   logic             w_smp_v;
   logic             w_trig_en;
   logic             w_trig;
   logic             w_we;

   assign w_dec_last = dec_last(set_dec_i);
   // >= keeps the counter from running away if the factor shrinks mid-count.
   assign w_smp_v    = (r_dec_cnt >= w_dec_last);

   // Abort and arm pulses both mask trigger detection in their cycle.
   assign w_trig_en  = (r_state == ARMED) && !set_rst_i && !set_arm_i;

   // The trigger cycle itself is not written, so tpnt names the first
   // post-trigger sample and exactly set_dly_i samples follow it.
   assign w_we = w_smp_v && !set_rst_i && !set_arm_i &&
                 (((r_state == ARMED) && !w_trig) ||
                  ((r_state == TRIG) && (r_dly_cnt != 32'd0)));

   acq_trig_det #(
      .DW (DW)
   ) u_trig_det (
      .clk_i      (adc_clk_i),
      .rst_i      (adc_rst_i),
      .en_i       (w_trig_en),
      .arm_i      (set_arm_i),
      .smp_v_i    (w_smp_v),
      .smp_i      (r_adc),
      .src_i      (trig_src_i),
      .trig_sw_i  (trig_sw_i),
      .trig_ext_i (trig_ext_i),
      .thr_i      (set_thr_i),
      .trig_o     (w_trig)
   );

   // Input sample register and decimation counter.
   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i) begin
         r_adc     <= '0;
         r_dec_cnt <= '0;
      end else begin
         r_adc <= adc_dat_i;
         if (set_arm_i || w_smp_v) begin
            r_dec_cnt <= '0;
         end else begin
            r_dec_cnt <= r_dec_cnt + DEC_W'(1);
         end
      end
   end

   // Capture FSM with registered busy/done outputs.
   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i) begin
         r_state   <= IDLE;
         r_wpnt    <= '0;
         r_tpnt    <= '0;
         r_dly_cnt <= '0;
         r_done    <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (set_rst_i) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
         end else if (set_arm_i) begin
            r_state <= ARMED;
            r_busy  <= 1'b1;
            r_wpnt  <= '0;
         end else begin
            case (r_state)
               ARMED: begin
                  if (w_trig) begin
                     r_state   <= TRIG;
                     r_tpnt    <= r_wpnt;
                     r_dly_cnt <= set_dly_i;
                  end else if (w_smp_v) begin
                     r_wpnt <= r_wpnt + RSZ'(1);
                  end
               end
               TRIG: begin
                  if (r_dly_cnt == 32'd0) begin
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else if (w_smp_v) begin
                     r_wpnt    <= r_wpnt + RSZ'(1);
                     r_dly_cnt <= r_dly_cnt - 32'd1;
                     if (r_dly_cnt == 32'd1) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end
                  end
               end
               default: begin
                  r_state <= r_state;
               end
            endcase
         end
      end
   end

   // Sample buffer write port; contents survive reset.
   always_ff @(posedge adc_clk_i) begin
      if (w_we) begin
         r_ram[r_wpnt] <= r_adc;
      end
   end

   // Registered readback; a same-address write returns the old word.
   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i) begin
         r_rdata <= '0;
      end else begin
         r_rdata <= r_ram[buf_addr_i];
      end
   end

   assign buf_rdata_o = r_rdata;
   assign buf_wpnt_o  = r_wpnt;
   assign buf_tpnt_o  = r_tpnt;
   assign trig_done_o = r_done;
   assign acq_busy_o  = r_busy;

endmodule : red_pitaya_acq_ch

// File: doc/red_pitaya_acq_ch.md
Name: red_pitaya_acq_ch

Overview:
- Single-channel ADC acquisition block: the receive-side counterpart of the ASG channel.
- Decimates ADC samples and writes them into a circular RAM while armed.
- Detects a trigger (software, external edge or level crossing), then captures a programmable number of post-trigger samples and stops.
- Buffer is read back by the bus side through an address/data port. Sits between the ADC front end and the system register bus, beside the ASG.

Parameters:
- RSZ, 14, buffer address width; buffer depth is 2^RSZ samples.
- DW, 14, ADC sample width, two's complement.

Ports:
- adc_clk_i  in  1  ADC clock; the only clock.
- adc_rst_i  in  1  asynchronous, active-high reset.
- adc_dat_i  in  DW  ADC sample, signed, one per clock.
- trig_sw_i  in  1  software trigger pulse.
- trig_ext_i  in  1  external trigger pin, asynchronous.
- trig_src_i  in  3  trigger source: 0 none, 1 sw, 2 ext rising, 3 ext falling, 4 level rising crossing, 5 immediate; 6 and 7 are treated as none.
- set_dec_i  in  17  decimation factor; 0 and 1 both mean no decimation.
- set_dly_i  in  32  number of post-trigger samples to capture.
- set_thr_i  in  DW  signed level-trigger threshold.
- set_arm_i  in  1  arm pulse.
- set_rst_i  in  1  synchronous abort/clear pulse.
- buf_addr_i  in  RSZ  readback address.
- buf_rdata_o  out  DW  readback data.
- buf_wpnt_o  out  RSZ  current write pointer.
- buf_tpnt_o  out  RSZ  write pointer latched at the trigger.
- trig_done_o  out  1  one-cycle pulse when capture completes.
- acq_busy_o  out  1  high in ARMED or TRIG.

Behaviour:
- Reset (async, adc_rst_i=1):
  - state IDLE.
  - wpnt, tpnt, dec_cnt, dly_cnt, sync/edge flops all 0.
  - buf_rdata_o=0, trig_done_o=0, acq_busy_o=0.
  - RAM contents are not reset.
- Decimation:
  - dec_cnt counts 0..N-1, where N=max(set_dec_i,1). Sample strobe smp_v is asserted when dec_cnt==N-1.
  - The sample written is adc_dat_i registered once; no averaging.
  - dec_cnt clears on set_arm_i.
- States: IDLE, ARMED, TRIG, DONE.
  - IDLE/DONE -> ARMED on set_arm_i. Clears wpnt and dec_cnt.
  - ARMED: each smp_v writes RAM[wpnt] and increments wpnt. wpnt wraps modulo 2^RSZ with no full flag.
  - ARMED -> TRIG on a detected trigger:
    - tpnt <= wpnt, i.e. the address of the next sample written.
    - dly_cnt <= set_dly_i.
    - A trigger in the same cycle as set_arm_i is ignored.
  - TRIG: each smp_v writes the sample and decrements dly_cnt. When dly_cnt==1 on a write, or when dly_cnt==0 on entry, go to DONE.
    - Exactly set_dly_i samples are written after the trigger.
    - set_dly_i=0 means zero post-trigger writes; DONE follows one cycle after the trigger.
  - DONE: no writes. trig_done_o pulses for the single cycle of entry into DONE.
- set_rst_i in any state -> IDLE next cycle. It has priority over set_arm_i, trigger and smp_v; wpnt and tpnt are held.
- set_arm_i in ARMED or TRIG re-arms: it restarts capture and drops the pending trigger.
- Trigger detection is evaluated only in ARMED:
  - Ext: 2-FF synchronizer, then a 1-flop edge detector. Latency from pin to trigger is 3 clocks.
  - sw: trig_sw_i is used directly.
  - Level: fires on a smp_v where prev_sample < set_thr_i <= cur_sample, compared signed. prev_sample updates on every smp_v and is cleared on arm.
  - Immediate (5): triggers on the first cycle in ARMED.
- Readback: buf_rdata_o <= RAM[buf_addr_i], registered, 1-cycle latency.
  - Simultaneous read and write at the same address returns the old data.
- buf_wpnt_o = wpnt and buf_tpnt_o = tpnt, both registered state.
- acq_busy_o = (state==ARMED)||(state==TRIG).

Decomposition:
- Package acq_pkg holds:
  - the state enum acq_state_t {IDLE, ARMED, TRIG, DONE};
  - trigger-source constants TRG_NONE..TRG_NOW;
  - decimation width constant DEC_W=17.
- Sub-module acq_trig_det holds the synchronizer, edge detectors, level comparator and source mux. Its output is a single-cycle trig_o qualified by an enable from the FSM.
- The RAM is inferred in the top module.

Test Plan:
- Reset mid-capture: assert adc_rst_i while in TRIG with wpnt=100 -> all outputs go to 0 immediately (async) and state is IDLE after release.
- Software trigger, no decimation:
  - Setup: dec=1, dly=8, src=1, ramp input, arm, trig_sw after 20 clocks.
  - Expected: tpnt=20, trig_done pulses exactly once, final wpnt=28, RAM[20..27] holds the ramp values.
- Decimation:
  - Setup: dec=4, dly=3, src=5, ramp input.
  - Expected: RAM holds every 4th sample; trig_done comes 12 clocks after the first write, give or take pipeline offset, checked against the model.
- Level trigger: thr=100, input steps -50 -> 99 -> 100 -> 200 -> fires on the 100 sample only; no re-fire on 200.
- Wrap and dly=0:
  - Setup: RSZ=4, arm, wait 40 samples, src=2 ext edge.
  - Expected: wpnt has wrapped to 8; trigger occurs 3 clocks after the pin edge; dly=0 gives DONE one clock after the trigger with no extra writes.
- Priority:
  - set_rst_i together with set_arm_i and a trigger in one cycle -> IDLE.
  - set_arm_i during TRIG -> ARMED with wpnt=0 and no trig_done.
